// File: rtl/mips_run_pkg.sv
// Shared definitions for the mips run controller: FSM state encoding,
// reset synchroniser depth and the channel release schedule helper.
package mips_run_pkg;

  // Number of flops in the reset release synchroniser.
  localparam int SYNC_STAGES = 2;

  // Legacy-compatible state codes; the enum below is built from them.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RST_SEQ = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RST_SEQ = ST_RST_SEQ,
    RUN     = ST_RUN,
    DONE    = ST_DONE
  } run_state_t;

  // Sequence count at which downstream channel ch leaves reset.
  function automatic int ch_release_seq(input int ch, input int hold, input int stagger);
    return hold + ch * stagger;
  endfunction

endpackage : mips_run_pkg

// File: rtl/mips_rst_sync.sv
// Reset synchroniser: asserts asynchronously, releases synchronously after
// STAGES rising clock edges. Shared with other blocks in the harness.
module mips_rst_sync
  import mips_run_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [STAGES-1:0] sync_q;

  // Shift a constant 1 through the chain once reset is released.
  // NOTE: sequential state is always written with <= so every flop samples
  // the pre-edge value of its neighbours; = here would collapse the chain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[STAGES-1];

endmodule : mips_rst_sync

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: synchronised reset release, staggered
// per-channel downstream resets, start/stop handshake and a cycle budget.
// Optional feature macro: MIPS_RUN_CTRL_PAUSE_EN adds a pause input that
// freezes the run counter (RUN) and the release sequence (RST_SEQ).
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int CYCLE_LIMIT = 1000,
  parameter int NUM_CH      = 2,
  parameter int RST_HOLD    = 3,
  parameter int CH_STAGGER  = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
`ifdef MIPS_RUN_CTRL_PAUSE_EN
  input  logic              pause,
`endif
  input  logic [CNT_W-1:0]  limit_in,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              run,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_cnt
);

  // Sequence count at which the last channel is released.
  localparam int SEQ_MAX = RST_HOLD + (NUM_CH - 1) * CH_STAGGER;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  logic rst_sync_n;
  logic pause_w;

  run_state_t        state_q,   state_d;
  logic [SEQ_W-1:0]  seq_q,     seq_d;
  logic [NUM_CH-1:0] ch_q,      ch_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [CNT_W-1:0]  limit_q,   limit_d;
  logic              timeout_q, timeout_d;

  logic [SEQ_W-1:0]  seq_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              at_limit;

  mips_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rst_sync (
    .clk_i   (CLK),
    .rst_n_i (reset),
    .rst_n_o (rst_sync_n)
  );

`ifdef MIPS_RUN_CTRL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign seq_nxt  = seq_q + SEQ_W'(1);
  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign at_limit = (cnt_q == limit_q - CNT_W'(1));

  // Next-state logic for the run FSM and its counters.
  // NOTE: every variable gets its hold value before the case statement, so
  // paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    timeout_d = timeout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RST_SEQ;
          seq_d     = '0;
          ch_d      = '0;
          cnt_d     = '0;
          timeout_d = 1'b0;
          limit_d   = (limit_in == '0) ? CNT_W'(CYCLE_LIMIT) : limit_in;
        end
      end

      RST_SEQ: begin
        if (stop) begin
          state_d   = DONE;
          timeout_d = 1'b0;
          ch_d      = '0;
        end else if (&ch_q) begin
          state_d = RUN;
        end else if (!pause_w) begin
          seq_d = seq_nxt;
          for (int k = 0; k < NUM_CH; k++) begin
            if (seq_nxt == SEQ_W'(ch_release_seq(k, RST_HOLD, CH_STAGGER))) begin
              ch_d[k] = 1'b1;
            end
          end
        end
      end

      RUN: begin
        if (pause_w) begin
          // Counter and limit check frozen; an abort is still accepted.
          if (stop) begin
            state_d   = DONE;
            timeout_d = 1'b0;
          end
        end else if (at_limit) begin
          // Budget expiry takes priority over a coincident stop.
          state_d   = DONE;
          timeout_d = 1'b1;
          cnt_d     = cnt_inc;
        end else if (stop) begin
          state_d   = DONE;
          timeout_d = 1'b0;
          cnt_d     = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers, cleared by the synchronised reset.
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      ch_q      <= '0;
      cnt_q     <= '0;
      limit_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      timeout_q <= timeout_d;
    end
  end

  assign ch_rst_n  = ch_q;
  assign run       = (state_q == RUN) && !pause_w;
  assign done      = (state_q == DONE);
  assign timeout   = timeout_q;
  assign cycle_cnt = cnt_q;

endmodule : mips_run_ctrl

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: reset/default-budget run, a vector
// table, hand sequences for stop/reset corners and randomized episodes
// checked against a timeline model built from the release/run/stop rules.
module tb_mips_run_ctrl;

  localparam int CNT_W   = 16;
  localparam int DEF_LIM = 1000;
  localparam int NCH     = 2;
  localparam int HOLD    = 3;
  localparam int STAG    = 2;
  localparam int SEQ_MAX = HOLD + (NCH - 1) * STAG;

  logic             CLK;
  logic             reset;
  logic             start;
  logic             stop;
`ifdef MIPS_RUN_CTRL_PAUSE_EN
  logic             pause;
`endif
  logic [CNT_W-1:0] limit_in;
  logic [NCH-1:0]   ch_rst_n;
  logic             run;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] lim;
    logic [31:0]      exp;
  } vec_t;

  vec_t vq[$];

  mips_run_ctrl #(
    .CNT_W       (CNT_W),
    .CYCLE_LIMIT (DEF_LIM),
    .NUM_CH      (NCH),
    .RST_HOLD    (HOLD),
    .CH_STAGGER  (STAG)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
`ifdef MIPS_RUN_CTRL_PAUSE_EN
    .pause     (pause),
`endif
    .limit_in  (limit_in),
    .ch_rst_n  (ch_rst_n),
    .run       (run),
    .done      (done),
    .timeout   (timeout),
    .cycle_cnt (cycle_cnt)
  );

  // Rising edges at 10, 20, 30 ... ns.
  initial begin
    CLK = 1'b0;
    #10;
    forever begin
      CLK = 1'b1;
      #5 CLK = 1'b0;
      #5;
    end
  end

  function automatic logic [31:0] pk(input bit r, input bit d, input bit t,
                                     input bit [NCH-1:0] ch, input int cnt);
    return {11'd0, r, d, t, ch, CNT_W'(cnt)};
  endfunction

  function automatic logic [31:0] outs();
    return {11'd0, run, done, timeout, ch_rst_n, cycle_cnt};
  endfunction

  function automatic bit [NCH-1:0] seq_ch(input int s);
    bit [NCH-1:0] c = '0;
    for (int k = 0; k < NCH; k++) if (s >= HOLD + k * STAG) c[k] = 1'b1;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (fields run,done,timeout,ch,cnt)",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One start-to-DONE episode. sc is the cycle (relative to RST_SEQ entry)
  // during which stop is raised, or -1 for none. Expected outputs come from
  // the release schedule and budget arithmetic, not from any state machine.
  task automatic run_episode(input int lim_in, input int sc, input string tag);
    int L, end_rel, e_cnt;
    bit e_to;
    bit [NCH-1:0] e_ch;
    logic [31:0] exp;
    L = (lim_in == 0) ? DEF_LIM : lim_in;
    if (sc >= 0 && sc <= SEQ_MAX) begin
      end_rel = sc + 1; e_cnt = 0; e_to = 1'b0; e_ch = '0;
    end else if (sc > SEQ_MAX && (sc - SEQ_MAX - 1) < L - 1) begin
      end_rel = sc + 1; e_cnt = sc - SEQ_MAX; e_to = 1'b0; e_ch = '1;
    end else begin
      end_rel = SEQ_MAX + 1 + L; e_cnt = L; e_to = 1'b1; e_ch = '1;
    end
    start    = 1'b1;
    stop     = 1'b0;
    limit_in = CNT_W'(lim_in);
    for (int i = 0; i <= end_rel + 2; i++) begin
      tick();
      if (i >= end_rel)      exp = pk(0, 1, e_to, e_ch, e_cnt);
      else if (i <= SEQ_MAX) exp = pk(0, 0, 0, seq_ch(i), 0);
      else                   exp = pk(1, 0, 0, '1, i - SEQ_MAX - 1);
      check(tag, outs(), exp);
      limit_in = CNT_W'($urandom);
      if (i < end_rel - 1 || (i == end_rel - 1 && end_rel > 0)) begin
        start = 1'($urandom_range(0, 1));
        stop  = (i == sc);
      end else begin
        start = 1'b0;
        stop  = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int n;
    int lim, mode, sc;
    start    = 1'b0;
    stop     = 1'b0;
    limit_in = '0;
`ifdef MIPS_RUN_CTRL_PAUSE_EN
    pause    = 1'b0;
`endif

    // ---- Reset, delayed release, default budget of 1000 cycles ----
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 check("reset_async", outs(), pk(0, 0, 0, '0, 0));
    #10 check("reset_after_edge", outs(), pk(0, 0, 0, '0, 0));
    #2 reset = 1'b1;          // t = 15 ns
    start    = 1'b1;
    limit_in = '0;
    repeat (3) tick();        // first edge that sees released reset is the 3rd
    start = 1'b0;
    check("seq_entry", outs(), pk(0, 0, 0, 2'b00, 0));
    repeat (2) tick();
    check("ch0_before", outs(), pk(0, 0, 0, 2'b00, 0));
    tick();
    check("ch0_release", outs(), pk(0, 0, 0, 2'b01, 0));
    tick();
    check("ch1_before", outs(), pk(0, 0, 0, 2'b01, 0));
    tick();
    check("ch1_release", outs(), pk(0, 0, 0, 2'b11, 0));
    tick();
    check("run_entry", outs(), pk(1, 0, 0, 2'b11, 0));
    n = 1;
    for (int b = 0; b < 1100 && !done; b++) begin
      tick();
      if (run) n++;
    end
    check("default_run_cycles", 32'(n), 32'(DEF_LIM));
    check("default_done", outs(), pk(0, 1, 1, 2'b11, DEF_LIM));

    // ---- Vector table: stop at RUN cycle 2 (limit 5), then limit 1 ----
    vq.push_back('{1, 0, 5, pk(0, 0, 0, 2'b00, 0)});
    for (int s = 1; s <= SEQ_MAX; s++) vq.push_back('{0, 0, 0, pk(0, 0, 0, seq_ch(s), 0)});
    vq.push_back('{0, 0, 0, pk(1, 0, 0, 2'b11, 0)});
    vq.push_back('{0, 0, 0, pk(1, 0, 0, 2'b11, 1)});
    vq.push_back('{0, 0, 0, pk(1, 0, 0, 2'b11, 2)});
    vq.push_back('{0, 1, 0, pk(0, 1, 0, 2'b11, 3)});
    vq.push_back('{0, 1, 0, pk(0, 1, 0, 2'b11, 3)});
    vq.push_back('{1, 0, 1, pk(0, 0, 0, 2'b00, 0)});
    for (int s = 1; s <= SEQ_MAX; s++) vq.push_back('{0, 0, 7, pk(0, 0, 0, seq_ch(s), 0)});
    vq.push_back('{0, 0, 0, pk(1, 0, 0, 2'b11, 0)});
    vq.push_back('{0, 0, 0, pk(0, 1, 1, 2'b11, 1)});
    vq.push_back('{0, 0, 0, pk(0, 1, 1, 2'b11, 1)});
    for (int v = 0; v < vq.size(); v++) begin
      start    = vq[v].start;
      stop     = vq[v].stop;
      limit_in = vq[v].lim;
      tick();
      check($sformatf("vec%0d", v), outs(), vq[v].exp);
    end
    start = 1'b0;
    stop  = 1'b0;

    // ---- Stop during RST_SEQ before channel 1 release, then restart ----
    run_episode(4, HOLD + 1, "stop_in_seq");
    run_episode(2, -1, "restart_after_seq_stop");
    run_episode(3, SEQ_MAX + 3, "stop_meets_limit");

    // ---- Randomized episodes ----
    for (int e = 0; e < 30; e++) begin
      lim  = $urandom_range(1, 24);
      mode = $urandom_range(0, 2);
      if (mode == 0)      sc = -1;
      else if (mode == 1) sc = $urandom_range(0, SEQ_MAX);
      else                sc = $urandom_range(SEQ_MAX + 1, SEQ_MAX + lim + 1);
      run_episode(lim, sc, $sformatf("rand%0d", e));
    end

    // ---- Reset pulled low mid-RUN at cycle_cnt = 40 ----
    start    = 1'b1;
    limit_in = CNT_W'(100);
    tick();
    start = 1'b0;
    for (int b = 0; b < 200 && cycle_cnt != CNT_W'(40); b++) tick();
    check("reach_cnt40", outs(), pk(1, 0, 0, 2'b11, 40));
    #2 reset = 1'b0;
    #1 check("midrun_reset_async", outs(), pk(0, 0, 0, 2'b00, 0));
    #1 reset = 1'b1;
    for (int b = 0; b < 3; b++) begin
      stop = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("idle_after_reset%0d", b), outs(), pk(0, 0, 0, 2'b00, 0));
    end
    stop = 1'b0;
    run_episode(6, -1, "after_midrun_reset");

`ifdef MIPS_RUN_CTRL_PAUSE_EN
    // ---- Pause for 4 cycles mid-run with limit 10 ----
    begin
      int n_state, n_low;
      start    = 1'b1;
      limit_in = CNT_W'(10);
      tick();
      start = 1'b0;
      repeat (SEQ_MAX + 1) tick();
      check("pause_run_entry", outs(), pk(1, 0, 0, 2'b11, 0));
      n_state = 1;
      n_low   = 0;
      for (int b = 0; b < 40; b++) begin
        pause = (n_state - 1 >= 3) && (n_state - 1 <= 6);
        #1;
        if (!run) n_low++;
        tick();
        if (done) break;
        n_state++;
      end
      pause = 1'b0;
      check("pause_state_cycles", 32'(n_state), 32'd14);
      check("pause_run_low", 32'(n_low), 32'd4);
      check("pause_done", outs(), pk(0, 1, 1, 2'b11, 10));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mips_run_ctrl
